// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - operand forwarding scoreboard with load-use stall detection
// Tracks producer tags for STAGES in-flight stages and resolves decode sources against them.
module fwd_scoreboard #(
    parameter int DATA_W           = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_SRC          = 3,
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_dest,
    input  logic                         issue_we,
    input  logic                         issue_is_load,
    input  logic                         stall_in,
    input  logic                         flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]           src_used,
    input  logic [NUM_SRC*DATA_W-1:0]    src_rf_data,
    input  logic [STAGES*DATA_W-1:0]     stage_data,
    output logic [NUM_SRC*DATA_W-1:0]    fwd_data,
    output logic [NUM_SRC-1:0]           fwd_hit,
    output logic                         hazard_stall,
    output logic [15:0]                  stall_count
);

    logic [STAGES-1:0]                 valid_q, valid_d;
    logic [STAGES-1:0]                 we_q, we_d;
    logic [STAGES-1:0]                 ld_q, ld_d;
    logic [STAGES-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
    logic [15:0]                       stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]                slot_haz;

    // Youngest matching producer wins; a load still short of its ready stage stalls instead.
    always_comb begin
        logic found;
        fwd_data = src_rf_data;
        fwd_hit  = '0;
        slot_haz = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            found = 1'b0;
            if (src_used[k] && (src_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                for (int i = 0; i < STAGES; i++) begin
                    if (!found && valid_q[i] && we_q[i] &&
                        (dest_q[i] == src_addr[k*REG_ADDR_W +: REG_ADDR_W])) begin
                        found = 1'b1;
                        if (ld_q[i] && (i < LOAD_READY_STAGE)) begin
                            slot_haz[k] = 1'b1;
                        end else begin
                            fwd_data[k*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
                            fwd_hit[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign hazard_stall = issue_valid & (|slot_haz);

    always_comb begin
        valid_d       = valid_q;
        we_d          = we_q;
        ld_d          = ld_q;
        dest_d        = dest_q;
        stall_count_d = stall_count_q;

        if (!stall_in) begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                valid_d[i] = valid_q[i-1];
                we_d[i]    = we_q[i-1];
                ld_d[i]    = ld_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
        end

        // Flush beats the external hold; a stalled decode becomes a bubble.
        if (flush) begin
            valid_d[0] = 1'b0;
        end else if (stall_in) begin
            valid_d[0] = valid_q[0];
        end else if (hazard_stall || !issue_valid) begin
            valid_d[0] = 1'b0;
        end else begin
            valid_d[0] = 1'b1;
            we_d[0]    = issue_we;
            ld_d[0]    = issue_is_load;
            dest_d[0]  = issue_dest;
        end

        if (hazard_stall && !stall_in && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            we_q          <= '0;
            ld_q          <= '0;
            dest_q        <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            we_q          <= we_d;
            ld_q          <= ld_d;
            dest_q        <= dest_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - self-checking bench for fwd_scoreboard
// Behavioural pipeline model checked every cycle, plus directed literal expectations.
module tb_fwd_scoreboard;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NS = 3;
    localparam int ST = 3;
    localparam int LRS = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic [RW-1:0]   issue_dest = '0;
    logic            issue_we = 1'b0;
    logic            issue_is_load = 1'b0;
    logic            stall_in = 1'b0;
    logic            flush = 1'b0;
    logic [NS*RW-1:0] src_addr = '0;
    logic [NS-1:0]   src_used = '0;
    logic [NS*DW-1:0] src_rf_data = {32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000};
    logic [ST*DW-1:0] stage_data = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
    logic [NS*DW-1:0] fwd_data;
    logic [NS-1:0]   fwd_hit;
    logic            hazard_stall;
    logic [15:0]     stall_count;

    logic            rst2_n = 1'b0;
    logic [8*DW-1:0] stage_data2 = '0;
    logic [NS*DW-1:0] fwd_data2;
    logic [NS-1:0]   fwd_hit2;
    logic            hazard_stall2;
    logic [15:0]     stall_count2;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_scoreboard #(.DATA_W(DW), .REG_ADDR_W(RW), .NUM_SRC(NS), .STAGES(ST),
                     .LOAD_READY_STAGE(LRS)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_we(issue_we), .issue_is_load(issue_is_load), .stall_in(stall_in),
        .flush(flush), .src_addr(src_addr), .src_used(src_used),
        .src_rf_data(src_rf_data), .stage_data(stage_data), .fwd_data(fwd_data),
        .fwd_hit(fwd_hit), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    // Deep pipeline whose self-feeding load keeps the hazard up 7 cycles in 8.
    fwd_scoreboard #(.DATA_W(DW), .REG_ADDR_W(RW), .NUM_SRC(NS), .STAGES(8),
                     .LOAD_READY_STAGE(7)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .issue_valid(1'b1), .issue_dest(5'd7),
        .issue_we(1'b1), .issue_is_load(1'b1), .stall_in(1'b0), .flush(1'b0),
        .src_addr({5'd0, 5'd0, 5'd7}), .src_used(3'b001), .src_rf_data(src_rf_data),
        .stage_data(stage_data2), .fwd_data(fwd_data2), .fwd_hit(fwd_hit2),
        .hazard_stall(hazard_stall2), .stall_count(stall_count2)
    );

    always #5 clk = ~clk;

    // Model: an ordered list of in-flight instructions, index 0 youngest.
    logic          m_v [ST];
    logic [RW-1:0] m_d [ST];
    logic          m_w [ST];
    logic          m_l [ST];
    int            m_cnt;

    function automatic void resolve(output logic [NS*DW-1:0] d, output logic [NS-1:0] h,
                                    output logic hz);
        logic any_haz;
        logic done;
        logic [RW-1:0] a;
        d = src_rf_data;
        h = '0;
        any_haz = 1'b0;
        for (int k = 0; k < NS; k++) begin
            a = src_addr[k*RW +: RW];
            done = 1'b0;
            if (src_used[k] && a != 0) begin
                for (int i = 0; i < ST; i++) begin
                    if (!done && m_v[i] && m_w[i] && m_d[i] == a) begin
                        done = 1'b1;
                        if (m_l[i] && i < LRS) any_haz = 1'b1;
                        else begin
                            d[k*DW +: DW] = stage_data[i*DW +: DW];
                            h[k] = 1'b1;
                        end
                    end
                end
            end
        end
        hz = issue_valid & any_haz;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [NS*DW-1:0] d;
        logic [NS-1:0] h;
        logic hz;
        if (!rst_n) begin
            for (int i = 0; i < ST; i++) begin
                m_v[i] <= 1'b0; m_d[i] <= '0; m_w[i] <= 1'b0; m_l[i] <= 1'b0;
            end
            m_cnt <= 0;
        end else begin
            resolve(d, h, hz);
            if (!stall_in) begin
                for (int i = 1; i < ST; i++) begin
                    m_v[i] <= m_v[i-1]; m_d[i] <= m_d[i-1];
                    m_w[i] <= m_w[i-1]; m_l[i] <= m_l[i-1];
                end
            end
            if (flush) m_v[0] <= 1'b0;
            else if (!stall_in) begin
                if (hz || !issue_valid) m_v[0] <= 1'b0;
                else begin
                    m_v[0] <= 1'b1; m_d[0] <= issue_dest;
                    m_w[0] <= issue_we; m_l[0] <= issue_is_load;
                end
            end
            if (hz && !stall_in && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NS*DW-1:0] d;
        logic [NS-1:0] h;
        logic hz;
        if (rst_n) begin
            resolve(d, h, hz);
            chk("model_fwd_data", fwd_data, d);
            chk("model_fwd_hit", fwd_hit, h);
            chk("model_hazard", hazard_stall, hz);
            chk("model_stall_count", stall_count, m_cnt[15:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [RW-1:0] dst, input logic we, input logic ld);
        issue_valid = v; issue_dest = dst; issue_we = we; issue_is_load = ld;
    endtask

    initial begin
        #2;
        chk("reset_fwd_hit", fwd_hit, 3'b000);
        chk("reset_hazard", hazard_stall, 1'b0);
        chk("reset_stall_count", stall_count, 16'h0);
        chk("reset_fwd_data", fwd_data, src_rf_data);
        #4 rst_n = 1'b1;

        // Basic EXE forward
        issue(1, 5'd3, 1, 0);
        step();
        issue(1, 5'd0, 0, 0);
        stage_data[31:0] = 32'h1234;
        src_addr[4:0] = 5'd3; src_used = 3'b001;
        #1;
        chk("exe_fwd_data", fwd_data[31:0], 32'h1234);
        chk("exe_fwd_hit", fwd_hit[0], 1'b1);
        chk("exe_no_hazard", hazard_stall, 1'b0);
        stage_data[31:0] = 32'hAA;
        step();

        // Youngest priority, then WB-only match
        issue(1, 5'd5, 1, 0); step();
        issue(1, 5'd5, 1, 0); step();
        issue(0, 5'd0, 0, 0);
        src_addr[4:0] = 5'd5;
        #1;
        chk("youngest_wins", fwd_data[31:0], 32'hAA);
        step(); step();
        chk("wb_only_data", fwd_data[31:0], 32'hCC);
        chk("wb_only_hit", fwd_hit[0], 1'b1);

        // Load-use stall
        src_used = 3'b000;
        issue(1, 5'd7, 1, 1); step();
        issue(1, 5'd8, 1, 0);
        src_addr[9:5] = 5'd7; src_used = 3'b010;
        #1;
        chk("loaduse_stall", hazard_stall, 1'b1);
        chk("loaduse_nohit", fwd_hit[1], 1'b0);
        chk("loaduse_rf", fwd_data[63:32], 32'hF1F1_0001);
        step();
        chk("loaduse_count", stall_count, 16'd1);
        chk("loaduse_released", hazard_stall, 1'b0);
        chk("loaduse_fwd_mem", fwd_data[63:32], 32'hBB);
        step();

        // r0 and unused slots
        issue(1, 5'd4, 1, 0); step();
        issue(1, 5'd0, 1, 0); step();
        issue(0, 5'd0, 0, 0);
        src_addr = {5'd4, 5'd4, 5'd0}; src_used = 3'b011;
        #1;
        chk("r0_and_unused_hit", fwd_hit, 3'b010);
        chk("r0_rf_pass", fwd_data[31:0], 32'hF0F0_0000);
        chk("unused_rf_pass", fwd_data[95:64], 32'hF2F2_0002);

        // Stall holds entries, then flush kills entry 0
        issue(1, 5'd9, 1, 0); step();
        issue(1, 5'd10, 1, 0);
        src_addr = {5'd0, 5'd0, 5'd9}; src_used = 3'b001;
        stall_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_frozen_data", fwd_data[31:0], 32'hAA);
        end
        stall_in = 1'b0; flush = 1'b1;
        issue(1, 5'd11, 1, 0);
        step();
        flush = 1'b0; issue(0, 5'd0, 0, 0);
        src_addr = {5'd0, 5'd9, 5'd11}; src_used = 3'b011;
        #1;
        chk("flush_entry0_dead", fwd_hit[0], 1'b0);
        chk("after_stall_shift", fwd_data[63:32], 32'hBB);

        // Reset mid-flight
        src_used = 3'b000;
        issue(1, 5'd12, 1, 0); step();
        issue(1, 5'd13, 1, 0); step();
        issue(1, 5'd14, 1, 0); step();
        issue(0, 5'd0, 0, 0);
        src_addr = {5'd14, 5'd13, 5'd12}; src_used = 3'b111;
        #1;
        chk("inflight_hits", fwd_hit, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("async_reset_hit", fwd_hit, 3'b000);
        chk("async_reset_count", stall_count, 16'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_no_fwd", fwd_hit, 3'b000);

        // Saturation on the deep instance
        src_used = 3'b000;
        rst2_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("sat_first_period", stall_count2, 16'd7);
        repeat (75000) @(posedge clk);
        #1;
        chk("sat_count", stall_count2, 16'hFFFF);
        repeat (16) @(posedge clk);
        #1;
        chk("sat_no_wrap", stall_count2, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding mux.
- Keeps its own shadow copy of producer tags (dest, write-enable, is-load) for STAGES in-flight stages (EXE, MEM, WB by default).
- Resolves NUM_SRC decode-stage source operands against that shadow copy, selects forwarded data with youngest-producer priority, and raises a load-use stall when the needed data is not ready yet.
- Sits between decode and execute, and replaces hand-wired per-stage hazard flags.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register index width
NUM_SRC, 3, number of source operands (rs, rt, store value)
STAGES, 3, tracked stages; index 0 = EXE (youngest), STAGES-1 = WB (oldest)
LOAD_READY_STAGE, 1, first stage index at which load data is valid on stage_data; range 0..STAGES-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode holds a valid instruction
issue_dest  in  REG_ADDR_W  destination register of decoding instruction
issue_we  in  1  decoding instruction writes issue_dest
issue_is_load  in  1  decoding instruction is a load
stall_in  in  1  external pipeline hold (e.g. memory wait)
flush  in  1  kill instruction entering stage 0
src_addr  in  NUM_SRC*REG_ADDR_W  source register indices, slot k at [k*REG_ADDR_W +: REG_ADDR_W]
src_used  in  NUM_SRC  slot k is actually read
src_rf_data  in  NUM_SRC*DATA_W  register-file read data per slot
stage_data  in  STAGES*DATA_W  result data per tracked stage, stage i at [i*DATA_W +: DATA_W]
fwd_data  out  NUM_SRC*DATA_W  selected operand per slot
fwd_hit  out  NUM_SRC  slot k was forwarded from a stage
hazard_stall  out  1  load-use stall request to decode/fetch
stall_count  out  16  saturating count of hazard_stall cycles

Behaviour:
- Shadow entries: STAGES entries, each holding {valid, dest, we, is_load}. Registered; cleared asynchronously when rst_n=0.
- Reset values:
  - All entries valid=0; stall_count=0.
  - Combinational outputs right after reset: fwd_hit=0, hazard_stall=0, fwd_data=src_rf_data.
- Shift rule, at each rising edge with rst_n=1:
  - stall_in=1: entries 1..STAGES-1 hold.
  - stall_in=0: entry[i] <= entry[i-1] for i>=1; old entry[STAGES-1] is discarded.
  - Entry 0, first matching row wins:
    - flush=1 -> valid=0. This applies even when stall_in=1.
    - stall_in=1 -> hold.
    - hazard_stall=1 or issue_valid=0 -> bubble (valid=0).
    - otherwise -> {1, issue_dest, issue_we, issue_is_load}.
- Match: entry i matches slot k when valid & we & dest==src_addr[k] & src_addr[k]!=0.
- Per-slot resolution (combinational, zero latency), for each slot k:
  - src_used[k]=0 or src_addr[k]==0: fwd_data=src_rf_data, fwd_hit=0, no hazard.
  - Otherwise take the lowest-index matching entry m (youngest wins; older matches are ignored).
    - If entry m is_load and m < LOAD_READY_STAGE: slot hazard=1, fwd_hit=0, fwd_data=src_rf_data.
    - Else: fwd_data=stage_data[m], fwd_hit=1.
  - No match: fwd_data=src_rf_data, fwd_hit=0.
- hazard_stall = issue_valid & OR(slot hazards). It is not gated by stall_in.
- Caller contract: while hazard_stall=1, decode holds and re-presents the same instruction. The block inserts the bubble itself.
- stall_count: increments by 1 on each edge where hazard_stall=1 and stall_in=0. Saturates at 16'hFFFF with no wrap.
- Reset mid-operation: all entries invalidate immediately (asynchronous). The next cycle forwards nothing.
- Simultaneous events:
  - flush together with hazard_stall: entry 0 is bubbled either way; stall_count still counts.
  - Two slots naming the same register resolve identically.

Test Plan:
- Basic EXE forward: issue add r3 (we=1, load=0), next cycle src_addr[0]=3, used, stage_data[0]=32'h1234 -> fwd_data[0]=32'h1234, fwd_hit[0]=1, hazard_stall=0.
- Youngest priority: r5 written by consecutive instrs, so entries 0 and 1 both match; stage_data[0]=0xAA, [1]=0xBB -> slot gets 0xAA. Separately, a WB-only match (entry 2) with stage_data[2]=0xCC -> slot gets 0xCC.
- Load-use: lw r7, then consumer of r7 -> hazard_stall=1 for exactly 1 cycle, bubble in entry 0, stall_count=1. Next cycle the load is in entry 1, fwd_data=stage_data[1], hazard_stall=0.
- r0 and unused slots: src_addr=0 with entry dest=0 and we=1 -> fwd_hit=0, rf data passes. src_used=0 with a matching r4 -> fwd_hit=0.
- Stall/flush: stall_in=1 for 3 cycles -> entries frozen, forwarding stable. Then flush=1 with issue_valid=1 -> entry 0 invalid next cycle, no forward from it.
- Reset mid-flight: three valid producers in flight, pulse rst_n low asynchronously -> fwd_hit=0 and stall_count=0 immediately. Saturation: hold a hazard for 65 540 cycles -> stall_count=16'hFFFF.
